// File: rtl/cpu_defs.sv
// Shared CPU definitions: interrupt-controller register map, FSM states
// and CTRL register bit layout.
package cpu_defs;

  // Interrupt controller register addresses
  localparam logic [1:0] IRQ_MASK = 2'd0;
  localparam logic [1:0] IRQ_PEND = 2'd1;
  localparam logic [1:0] IRQ_EDGE = 2'd2;
  localparam logic [1:0] IRQ_CTRL = 2'd3;

  // Interrupt handshake FSM; encoding 3 is unused and recovers to IDLE
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } irq_state_t;

  // CTRL register layout: {24'b0, state[1:0], id[4:0], gie}
  localparam int CTRL_GIE_BIT   = 0;
  localparam int CTRL_ID_LSB    = 1;
  localparam int CTRL_STATE_LSB = 6;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of a request vector
// (index 0 wins) plus a valid flag. Purely combinational.
module irq_prio_enc #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    vec,
  output logic [ID_W-1:0] id,
  output logic            valid
);

  // Scan from the top down so the lowest set index is the last assignment
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    id    = '0;
    valid = |vec;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        id = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller for the pipelined core: latches/masks N_SRC request
// lines, picks the lowest-index eligible source, offers it over an
// irq_req/irq_ack handshake and holds it in service until eret.
module irq_ctrl
  import cpu_defs::*;
#(
  parameter int               N_SRC        = 4,
  parameter int               ID_W         = 2,
  parameter logic [N_SRC-1:0] EDGE_DEFAULT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [31:0]      data_in,
  output logic [31:0]      data_out,
  output logic             irq_req,
  output logic [ID_W-1:0]  irq_id,
  input  logic             irq_ack,
  input  logic             eret
);

  logic [N_SRC-1:0] r_mask;
  logic [N_SRC-1:0] r_pend;
  logic [N_SRC-1:0] r_edge;
  logic [N_SRC-1:0] r_prev;
  logic             r_gie;
  irq_state_t       r_state;
  logic             r_irq_req;
  logic [ID_W-1:0]  r_irq_id;

  irq_state_t       w_state_nxt;
  logic [ID_W-1:0]  w_id_nxt;
  logic             w_ack_take;
  logic [N_SRC-1:0] w_elig;
  logic [ID_W-1:0]  w_enc_id;
  logic             w_enc_valid;
  logic [N_SRC-1:0] w_w1c;
  logic [N_SRC-1:0] w_ack_clr;
  logic [N_SRC-1:0] w_set;
  logic [N_SRC-1:0] w_pend_nxt;
  logic             w_unused;

  // Write data above N_SRC (and above gie for CTRL) is deliberately dropped
  assign w_unused = &{1'b0, data_in};

  assign w_elig = r_pend & r_mask & {N_SRC{r_gie}};

  irq_prio_enc #(
    .N    (N_SRC),
    .ID_W (ID_W)
  ) u_prio (
    .vec   (w_elig),
    .id    (w_enc_id),
    .valid (w_enc_valid)
  );

  // Pending update: edge bits are sticky (set beats clear), level bits track the line
  always_comb begin
    w_w1c      = (we && addr == IRQ_PEND) ? data_in[N_SRC-1:0] : '0;
    w_ack_clr  = w_ack_take ? (N_SRC'(1) << r_irq_id) : '0;
    w_set      = irq_src & ~r_prev;
    w_pend_nxt = (r_edge & ((r_pend & ~(w_w1c | w_ack_clr)) | w_set))
               | (~r_edge & irq_src);
  end

  // Handshake FSM next-state: id is latched only when leaving IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_id_nxt    = r_irq_id;
    w_ack_take  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_enc_valid) begin
          w_state_nxt = ST_REQ;
          w_id_nxt    = w_enc_id;
        end
      end
      ST_REQ: begin
        if (irq_ack) begin
          w_state_nxt = ST_SERV;
          w_ack_take  = 1'b1;
        end
      end
      ST_SERV: begin
        if (eret) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, request and id registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_irq_req <= 1'b0;
      r_irq_id  <= '0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
      r_state   <= w_state_nxt;
      r_irq_req <= (w_state_nxt == ST_REQ);
      r_irq_id  <= w_id_nxt;
    end
  end

  // Configuration registers, pending vector and source history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask <= '0;
      r_pend <= '0;
      r_edge <= EDGE_DEFAULT;
      r_prev <= '0;
      r_gie  <= 1'b0;
    end else begin
      r_prev <= irq_src;
      r_pend <= w_pend_nxt;
      if (we && addr == IRQ_MASK) r_mask <= data_in[N_SRC-1:0];
      if (we && addr == IRQ_EDGE) r_edge <= data_in[N_SRC-1:0];
      if (we && addr == IRQ_CTRL) r_gie  <= data_in[CTRL_GIE_BIT];
    end
  end

  // Combinational register read; unimplemented bits read as zero
  always_comb begin
    data_out = '0;
    case (addr)
      IRQ_MASK: data_out[N_SRC-1:0] = r_mask;
      IRQ_PEND: data_out[N_SRC-1:0] = r_pend;
      IRQ_EDGE: data_out[N_SRC-1:0] = r_edge;
      default: begin
        data_out[CTRL_GIE_BIT]            = r_gie;
        data_out[CTRL_ID_LSB +: ID_W]     = r_irq_id;
        data_out[CTRL_STATE_LSB +: 2]     = r_state;
      end
    endcase
  end

  assign irq_req = r_irq_req;
  assign irq_id  = r_irq_id;

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Consumer end of the peripheral interrupt lines (timer INT and others) for the pipelined MIPS core.
- Latches and masks up to N request lines, selects one by fixed priority and presents it to the pipeline over a req/ack handshake.
- Holds it in service until the pipeline signals eret.
- The CPU configures it through a small memory-mapped register port (we/addr/data_in/data_out), the same style as the peripheral write port.

Parameters:
N_SRC, 4, number of interrupt source lines (1..32); index 0 is highest priority
ID_W, 2, width of irq_id; must satisfy 2**ID_W >= N_SRC
EDGE_DEFAULT, 4'b0000, reset value of EDGE_SEL (1 = rising-edge source, 0 = level source)

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  reset; asynchronous, active-high
irq_src  in  N_SRC  interrupt request lines, synchronous to clk; timer INT is bit 0
we  in  1  register write strobe
addr  in  2  register select: 0 MASK, 1 PENDING, 2 EDGE_SEL, 3 CTRL
data_in  in  32  write data
data_out  out  32  read data, combinational from addr
irq_req  out  1  interrupt request to pipeline, registered
irq_id  out  ID_W  index of requested/in-service source, registered
irq_ack  in  1  pipeline has taken the exception; valid only while irq_req=1
eret  in  1  pipeline executed eret; ends service

Behaviour:
- Reset (async): MASK=0, PENDING=0, EDGE_SEL=EDGE_DEFAULT, CTRL.gie=0, prev_src=0, state=IDLE, irq_req=0, irq_id=0. Reset mid-handshake or mid-service drops irq_req immediately and returns to IDLE.
- Edge sources:
  - PENDING[i] is set at the posedge where irq_src[i]=1 and prev_src[i]=0.
  - It is cleared by a write of 1 to PENDING bit i, or automatically on irq_ack with irq_id=i.
  - Set and clear in the same cycle: set wins.
- Level sources: PENDING[i] mirrors irq_src[i] registered one cycle (it is a flop). W1C and ack have no effect. The handler must clear the cause at the source, e.g. by rewriting the timer compare value.
- Bits >= N_SRC of every register read as 0 and ignore writes.
- Register access:
  - MASK RW; EDGE_SEL RW.
  - PENDING reads the pending vector; writes are W1C.
  - CTRL: bit0 gie RW. Read value = {24'b0, state[1:0], ID_W-bit irq_id zero-extended to 5 bits, gie}, i.e. bits 7:6 state, 5:1 id, 0 gie.
  - A write takes effect at the posedge where we=1.
- eligible = PENDING & MASK & {N_SRC{gie}}.
- FSM states IDLE=0, REQ=1, SERV=2:
  - IDLE: if eligible != 0, latch irq_id = lowest set index, go to REQ, and assert irq_req from the next cycle.
  - REQ: irq_req=1. irq_id is frozen; there is no re-prioritisation and no withdrawal, even if the source drops or is masked. On irq_ack, go to SERV, drop irq_req next cycle, and auto-clear PENDING[irq_id] if it is an edge source.
  - SERV: irq_req=0, irq_id held. No nesting; new edges still set PENDING. On eret, go to IDLE. The earliest next REQ is the cycle after IDLE is reached.
  - eret in IDLE/REQ and irq_ack outside REQ are ignored.
- Latency: a source edge sampled at posedge k gives PENDING=1 after k, state=REQ and irq_req=1 after k+1. Two cycles from source to irq_req.
- State encoding 3 is illegal and returns to IDLE.

Decomposition:
- Shared package (cpu_defs): register address constants IRQ_MASK/IRQ_PEND/IRQ_EDGE/IRQ_CTRL, FSM state constants, CTRL bit positions.
- One natural sub-module: irq_prio_enc (N_SRC-bit vector to lowest-index ID_W id plus valid). Parameterised and combinational, reused by the CP0 cause logic.

Test Plan:
- Reset, then write MASK=4'b0001, CTRL=1, with bit 0 level. Raise irq_src[0] at cycle 10 -> irq_req=1 at cycle 12, irq_id=0. Ack at 14 -> irq_req=0 at 15, state SERV (CTRL read bits 7:6 = 2). eret -> IDLE. Source still high -> irq_req re-asserts 2 cycles later.
- EDGE_SEL=4'b1111, MASK=4'b1111, gie=1. Pulse src[2] and src[1] in the same cycle -> irq_id=1. After ack, PENDING=4'b0100. After eret -> irq_id=2 request.
- Edge src[3] pending with MASK=0 -> no irq_req. Write MASK=4'b1000 -> irq_req after 1 cycle. W1C PENDING=4'b1000 in the same cycle as a new src[3] edge -> PENDING[3] stays 1.
- In REQ with level src[0], drop src[0] and clear MASK before ack -> irq_req stays 1 with id 0 until ack. eret with no ack -> ignored.
- Assert rst asynchronously (mid-cycle) during SERV -> irq_req=0, data_out for CTRL=0, MASK=0 immediately. No request after reset deasserts, even with sources high.
- Write data_in=32'hFFFF_FFFF to MASK with N_SRC=4 -> MASK reads 32'h0000_000F.
